sm_display_decoder: RTL and testbench

SM_DISPLAY_DECODER -- requirements
Module: sm_display_decoder

---
 rtl/sm_display_decoder.sv | 166 ++++++++++++++++
 tb/tb_sm_display_decoder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sm_display_decoder.sv
// sm_display_decoder
//   Captures a 4-bit sign-magnitude ALU result and multiplexes it onto a
//   two-digit 7-segment display (sign digit, magnitude digit).
//   It also presents the held value in two's complement form.
//
// Parameters
//   REFRESH_DIV  clock cycles each digit stays lit (2..65535)
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   in_result carries a result to capture
//   in_ready   registered; high while idle and on the last magnitude cycle
//   in_result  bit 3 = sign (1 = negative), bits 2:0 = magnitude
//   seg        active-high segments {g,f,e,d,c,b,a}
//   an         active-high digit enables {sign, magnitude}, one-hot or zero
//   out_twos   5-bit two's-complement value of the held result
//   neg_zero   held result is sign=1, magnitude=0
//
// Build option
//   NEG_ZERO_CANON_EN  when defined, a captured negative zero (1000) is
//                      stored as positive zero (0000).
module sm_display_decoder #(
  parameter int REFRESH_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_result,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [4:0] out_twos,
  output logic       neg_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SIGN = 2'd1,
    MAG  = 2'd2
  } state_t;

  localparam logic [15:0] LAST = 16'(REFRESH_DIV - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [3:0]  held, held_nxt;
  logic [3:0]  canon;
  logic        capture;

  logic        ready_nxt;
  logic [1:0]  an_nxt;
  logic [6:0]  seg_nxt;

  function automatic logic [6:0] sign_seg(input logic [3:0] v);
    return v[3] ? 7'b1000000 : 7'b0000000;
  endfunction

  function automatic logic [6:0] mag_seg(input logic [2:0] m);
    logic [6:0] s;
    case (m)
      3'd0:    s = 7'b0111111;
      3'd1:    s = 7'b0000110;
      3'd2:    s = 7'b1011011;
      3'd3:    s = 7'b1001111;
      3'd4:    s = 7'b1100110;
      3'd5:    s = 7'b1101101;
      3'd6:    s = 7'b1111101;
      default: s = 7'b0000111;
    endcase
    return s;
  endfunction

  function automatic logic signed [4:0] to_twos(input logic [3:0] v);
    logic signed [4:0] m;
    m = {2'b00, v[2:0]};
    return v[3] ? -m : m;
  endfunction

  assign capture = in_valid && in_ready;

`ifdef NEG_ZERO_CANON_EN
  assign canon = (in_result == 4'b1000) ? 4'b0000 : in_result;
`else
  assign canon = in_result;
`endif

  // Next state, refresh counter and held value
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 16'd1;
    held_nxt  = held;
    unique case (state)
      IDLE: begin
        cnt_nxt = 16'd0;
        if (capture) begin
          held_nxt  = canon;
          state_nxt = SIGN;
        end
      end
      SIGN: begin
        if (cnt == LAST) begin
          state_nxt = MAG;
          cnt_nxt   = 16'd0;
        end
      end
      MAG: begin
        if (cnt == LAST) begin
          // A capture is only possible here, so the new value always
          // starts on a fresh sign digit and a frame is never torn.
          state_nxt = SIGN;
          cnt_nxt   = 16'd0;
          if (capture) held_nxt = canon;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 16'd0;
      end
    endcase
  end

  // Output decode from the next-cycle state so every output is a flop
  always_comb begin
    ready_nxt = (state_nxt == IDLE) || ((state_nxt == MAG) && (cnt_nxt == LAST));
    an_nxt    = 2'b00;
    seg_nxt   = 7'b0000000;
    unique case (state_nxt)
      SIGN: begin
        an_nxt  = 2'b10;
        seg_nxt = sign_seg(held_nxt);
      end
      MAG: begin
        an_nxt  = 2'b01;
        seg_nxt = mag_seg(held_nxt[2:0]);
      end
      default: begin
        an_nxt  = 2'b00;
        seg_nxt = 7'b0000000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 16'd0;
      held     <= 4'b0000;
      in_ready <= 1'b1;
      an       <= 2'b00;
      seg      <= 7'b0000000;
      out_twos <= 5'b00000;
      neg_zero <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      held     <= held_nxt;
      in_ready <= ready_nxt;
      an       <= an_nxt;
      seg      <= seg_nxt;
      out_twos <= to_twos(held_nxt);
      neg_zero <= (held_nxt == 4'b1000);
    end
  end

endmodule

// File: tb/tb_sm_display_decoder.sv
module tb_sm_display_decoder;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_result;
  logic [6:0] seg;
  logic [1:0] an;
  logic [4:0] out_twos;
  logic       neg_zero;

  int tests = 0;
  int fails = 0;

  // Reference model: time since last capture plus the held value
  bit         m_idle = 1'b1;
  logic [3:0] m_held = 4'b0000;
  int         m_k    = 0;
  logic [6:0] digit_tab [8];

  always #5 clk = ~clk;

  sm_display_decoder #(.REFRESH_DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_result(in_result),
    .seg      (seg),
    .an       (an),
    .out_twos (out_twos),
    .neg_zero (neg_zero)
  );

  function automatic logic [3:0] m_store(input logic [3:0] r);
`ifdef NEG_ZERO_CANON_EN
    return (r == 4'b1000) ? 4'b0000 : r;
`else
    return r;
`endif
  endfunction

  function automatic bit m_ready();
    return m_idle || ((m_k % (2 * DIV)) == (2 * DIV - 1));
  endfunction

  function automatic bit m_sign_phase();
    return (m_k % (2 * DIV)) < DIV;
  endfunction

  function automatic logic [1:0] exp_an();
    if (m_idle) return 2'b00;
    return m_sign_phase() ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [6:0] exp_seg();
    if (m_idle) return 7'b0000000;
    if (m_sign_phase()) return m_held[3] ? 7'b1000000 : 7'b0000000;
    return digit_tab[m_held[2:0]];
  endfunction

  function automatic logic [4:0] exp_twos();
    int v;
    v = int'(m_held[2:0]);
    if (m_held[3]) v = -v;
    return 5'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [3:0] d);
    bit cap;
    rst       = r;
    in_valid  = v;
    in_result = d;
    cap = v && m_ready();
    @(posedge clk);
    if (r) begin
      m_idle = 1'b1;
      m_held = 4'b0000;
      m_k    = 0;
    end else if (cap) begin
      m_idle = 1'b0;
      m_held = m_store(d);
      m_k    = 0;
    end else if (!m_idle) begin
      m_k++;
    end
    #1;
    chk("in_ready", 32'(in_ready), 32'(m_ready()));
    chk("an",       32'(an),       32'(exp_an()));
    chk("seg",      32'(seg),      32'(exp_seg()));
    chk("out_twos", 32'(out_twos), 32'(exp_twos()));
    chk("neg_zero", 32'(neg_zero), 32'(m_held == 4'b1000));
  endtask

  initial begin
    digit_tab[0] = 7'b0111111; digit_tab[1] = 7'b0000110;
    digit_tab[2] = 7'b1011011; digit_tab[3] = 7'b1001111;
    digit_tab[4] = 7'b1100110; digit_tab[5] = 7'b1101101;
    digit_tab[6] = 7'b1111101; digit_tab[7] = 7'b0000111;

    // Reset state, including reset overriding a simultaneous capture
    cyc(1'b1, 1'b0, 4'h0);
    cyc(1'b1, 1'b1, 4'h7);
    chk("rst_an",    32'(an),       32'(2'b00));
    chk("rst_ready", 32'(in_ready), 32'(1'b1));
    chk("rst_twos",  32'(out_twos), 32'(5'b00000));

    // Capture 1011 (-3) and watch one full frame
    cyc(1'b0, 1'b1, 4'b1011);
    chk("r27_an0",   32'(an),       32'(2'b10));
    chk("r27_seg0",  32'(seg),      32'(7'b1000000));
    chk("r27_twos",  32'(out_twos), 32'(5'b11101));
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 4'h0);
    chk("r27_an1",   32'(an),       32'(2'b01));
    chk("r27_seg1",  32'(seg),      32'(7'b1001111));
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 4'h0);
    chk("r27_an2",   32'(an),       32'(2'b10));

    // in_valid held high: second value waits for the last magnitude cycle
    cyc(1'b1, 1'b0, 4'h0);
    cyc(1'b0, 1'b1, 4'b0101);
    chk("r28_busy",  32'(in_ready), 32'(1'b0));
    for (int i = 0; i < 2 * DIV; i++) cyc(1'b0, 1'b1, 4'b0110);
    chk("r28_an",    32'(an),       32'(2'b10));
    chk("r28_seg",   32'(seg),      32'(7'b0000000));
    chk("r28_twos",  32'(out_twos), 32'(5'b00110));

    // Negative zero
    cyc(1'b1, 1'b0, 4'h0);
    cyc(1'b0, 1'b1, 4'b1000);
    chk("r29_twos",  32'(out_twos), 32'(5'b00000));
`ifdef NEG_ZERO_CANON_EN
    chk("r29_nz",    32'(neg_zero), 32'(1'b0));
    chk("r29_seg",   32'(seg),      32'(7'b0000000));
`else
    chk("r29_nz",    32'(neg_zero), 32'(1'b1));
    chk("r29_seg",   32'(seg),      32'(7'b1000000));
`endif
    for (int i = 0; i < 2 * DIV; i++) cyc(1'b0, 1'b0, 4'h0);

    // Reset during the magnitude digit of 0111
    cyc(1'b1, 1'b0, 4'h0);
    cyc(1'b0, 1'b1, 4'b0111);
    for (int i = 0; i < DIV + 1; i++) cyc(1'b0, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 4'h0);
    chk("r30_an",    32'(an),       32'(2'b00));
    chk("r30_seg",   32'(seg),      32'(7'b0000000));
    chk("r30_twos",  32'(out_twos), 32'(5'b00000));
    chk("r30_ready", 32'(in_ready), 32'(1'b1));
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'h0);

    // Sweep all codes through a full frame
    for (int c = 0; c < 16; c++) begin
      cyc(1'b1, 1'b0, 4'h0);
      cyc(1'b0, 1'b1, 4'(c));
      for (int i = 0; i < 2 * DIV; i++) cyc(1'b0, 1'b0, 4'h0);
    end

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
